// File: rtl/modport_bus_pkg.sv
// Shared types and constants for the modport_bus handshake manager.
package modport_bus_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int DATA_W_DEF      = 16;
  localparam int DEPTH_DEF       = 256;
  localparam int WAIT_CYCLES_DEF = 1;

  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/modport_bus_regfile.sv
// Register file for modport_bus: async-clear array, one synchronous write port,
// one registered read port.
module modport_bus_regfile #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/modport_bus.sv
// Four-phase as/ds/da bus manager serving reads and writes from a local register file.
// Define MODPORT_BUS_TRACE_EN for simulation-only reset/transfer display messages.
//
// state | meaning
// IDLE  | waiting for as
// ADDR  | addr/rw latched, waiting for ds (as dropping aborts)
// WAIT  | counting WAIT_CYCLES before acknowledge
// ACK   | first cycle performs the access and raises da; holds until as=ds=0
module modport_bus
  import modport_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as,
  input  logic              rw,
  input  logic              ds,
  input  logic [DATA_W-1:0] wdata,
  output logic              da,
  output logic [DATA_W-1:0] data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_word;

  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[IDX_W-1:0];
  assign rd_word  = in_range ? mem_rdata : DATA_W'(DEAD_WORD);

  // Read is issued when ds is accepted so the registered port has settled by ACK entry.
  assign mem_re = (state == ADDR) && ds && (rw_q == RW_READ) && in_range;
  assign mem_we = (state == ACK) && !da && (rw_q == RW_WRITE) && in_range;

  modport_bus_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (idx),
    .wdata (wdata_q),
    .re    (mem_re),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      rw_q     <= RW_READ;
      wdata_q  <= '0;
      da       <= 1'b0;
      data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (as) begin
            addr_q <= addr;
            rw_q   <= rw;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (ds) begin
            if (rw_q == RW_WRITE) wdata_q <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              wait_cnt <= 4'(WAIT_CYCLES);
              state    <= WAIT;
            end
          end else if (!as) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ACK;
        end
        ACK: begin
          if (!da) begin
            da   <= 1'b1;
            data <= (rw_q == RW_READ) ? rd_word : '0;
          end else if (!as && !ds) begin
            da    <= 1'b0;
            data  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MODPORT_BUS_TRACE_EN
  always @(negedge rst) $display("Manager Rst");

  always @(posedge clk) begin
    if (rst && state == ACK && !da)
      $display("Manager Print rw=%0d addr=%0h data=%0h", rw_q, addr_q,
               (rw_q == RW_WRITE) ? wdata_q : rd_word);
  end
`endif

endmodule

// File: tb/tb_modport_bus.sv
// Bench for modport_bus: three instances (WAIT_CYCLES 0/1/3, DEPTH 16) on shared
// requester signals, checked against an array model of the register file.
module tb_modport_bus;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        as;
  logic        rw;
  logic        ds;
  logic [15:0] wdata;
  logic        da0, da1, da3;
  logic [15:0] data0, data1, data3;

  logic [2:0]  da_v;
  logic [15:0] data_v [3];
  int          wv [3] = '{0, 1, 3};

  logic [15:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  assign da_v      = {da3, da1, da0};
  assign data_v[0] = data0;
  assign data_v[1] = data1;
  assign data_v[2] = data3;

  modport_bus #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .addr(addr), .as(as), .rw(rw), .ds(ds), .wdata(wdata),
    .da(da0), .data(data0));
  modport_bus #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .addr(addr), .as(as), .rw(rw), .ds(ds), .wdata(wdata),
    .da(da1), .data(data1));
  modport_bus #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .addr(addr), .as(as), .rw(rw), .ds(ds), .wdata(wdata),
    .da(da3), .data(data3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expect_read(input logic [7:0] a);
    return (a < DEPTH) ? model[a] : 16'hDEAD;
  endfunction

  // One complete transfer; hold = extra cycles as/ds stay high after every instance acked.
  task automatic xfer(input logic r, input logic [7:0] a, input logic [15:0] wd, input int hold);
    logic [15:0] exp;
    int lat [3];
    exp = expect_read(a);
    @(negedge clk);
    addr = a; rw = r; as = 1'b1; ds = 1'b0; wdata = 16'h0BAD;
    @(negedge clk);
    ds = 1'b1; wdata = wd;
    lat = '{-1, -1, -1};
    for (int k = 0; k < 20 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (da_v[i] && lat[i] < 0) lat[i] = k;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency_w%0d a=%0h", wv[i], a), lat[i], wv[i] + 1);
      check($sformatf("da_high_w%0d a=%0h", wv[i], a), 32'(da_v[i]), 1);
      if (r) check($sformatf("rdata_w%0d a=%0h", wv[i], a), 32'(data_v[i]), 32'(exp));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ds = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_da_w%0d c=%0d", wv[i], h), 32'(da_v[i]), 1);
        if (r) check($sformatf("hold_data_w%0d c=%0d", wv[i], h), 32'(data_v[i]), 32'(exp));
      end
    end
    as = 1'b0; ds = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("exit_da_w%0d a=%0h", wv[i], a), 32'(da_v[i]), 0);
      check($sformatf("exit_data_w%0d a=%0h", wv[i], a), 32'(data_v[i]), 0);
    end
    if (!r && a < DEPTH) model[a] = wd;
  endtask

  task automatic abort_xfer(input logic r, input logic [7:0] a);
    @(negedge clk);
    addr = a; rw = r; as = 1'b1; ds = 1'b0; wdata = 16'hFFFF;
    @(negedge clk);
    as = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_da c=%0d", c), 32'(da_v), 0);
    end
  endtask

  initial begin
    logic [7:0]  ra;
    logic [15:0] rd;
    logic        rr;
    rst = 1'b0; addr = '0; as = 1'b0; rw = 1'b0; ds = 1'b0; wdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    check("reset_da", 32'(da_v), 0);
    for (int i = 0; i < 3; i++) check($sformatf("reset_data_w%0d", wv[i]), 32'(data_v[i]), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    xfer(1'b0, 8'h0C, 16'hA5C3, 0);
    xfer(1'b1, 8'h0C, 16'h0000, 0);
    xfer(1'b1, 8'h00, 16'h0000, 0);
    xfer(1'b0, 8'h0F, 16'h1234, 0);
    xfer(1'b1, 8'h0F, 16'h0000, 0);

    xfer(1'b1, 8'h20, 16'h0000, 0);
    xfer(1'b0, 8'h20, 16'hBEEF, 0);
    xfer(1'b0, 8'h10, 16'hCAFE, 0);
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 8'(i), 16'h0000, 0);

    abort_xfer(1'b0, 8'h0C);
    xfer(1'b1, 8'h0C, 16'h0000, 0);
    abort_xfer(1'b1, 8'h03);
    xfer(1'b1, 8'h03, 16'h0000, 0);

    xfer(1'b1, 8'h0C, 16'h0000, 10);
    xfer(1'b0, 8'h05, 16'h5A5A, 10);

    for (int n = 0; n < 40; n++) begin
      rr = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 31));
      rd = 16'($urandom);
      xfer(rr, ra, rd, int'($urandom_range(0, 2)));
    end

    // Reset while every instance sits in ACK with as/ds still held.
    @(negedge clk);
    addr = 8'h0C; rw = 1'b1; as = 1'b1; ds = 1'b0;
    @(negedge clk);
    ds = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_reset_da", 32'(da_v), 3'b111);
    #2 rst = 1'b0;
    #1;
    check("async_reset_da", 32'(da_v), 0);
    for (int i = 0; i < 3; i++) check($sformatf("async_reset_data_w%0d", wv[i]), 32'(data_v[i]), 0);
    as = 1'b0; ds = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 8'(i), 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
